// File: rtl/cycle_sequencer_pkg.sv
// Shared timing definitions for the CPU subcycle sequencer: subcycle codes,
// state encoding, one-hot masks and helpers that map a state onto its outputs.
package cpu_timing_pkg;

  localparam logic [2:0] SC_A1 = 3'd0;
  localparam logic [2:0] SC_A2 = 3'd1;
  localparam logic [2:0] SC_A3 = 3'd2;
  localparam logic [2:0] SC_M1 = 3'd3;
  localparam logic [2:0] SC_M2 = 3'd4;
  localparam logic [2:0] SC_X1 = 3'd5;
  localparam logic [2:0] SC_X2 = 3'd6;
  localparam logic [2:0] SC_X3 = 3'd7;

  localparam logic [3:0] HOLD_CODE = 4'd8;
  localparam int WAIT_MAX_DEFAULT = 15;

  localparam logic [7:0] OH_NONE = 8'h00;
  localparam logic [7:0] OH_A1   = 8'h01;

  // The low three bits of a non-HOLD state are its subcycle number.
  typedef enum logic [3:0] {
    ST_A1   = {1'b0, SC_A1},
    ST_A2   = {1'b0, SC_A2},
    ST_A3   = {1'b0, SC_A3},
    ST_M1   = {1'b0, SC_M1},
    ST_M2   = {1'b0, SC_M2},
    ST_X1   = {1'b0, SC_X1},
    ST_X2   = {1'b0, SC_X2},
    ST_X3   = {1'b0, SC_X3},
    ST_HOLD = HOLD_CODE
  } state_t;

  function automatic logic [7:0] oneHotOf(input state_t s);
    logic [3:0] code;
    code = s;
    return (s == ST_HOLD) ? OH_NONE : (OH_A1 << code[2:0]);
  endfunction

  function automatic logic [2:0] subCycOf(input state_t s);
    logic [3:0] code;
    code = s;
    return (s == ST_HOLD) ? SC_X3 : code[2:0];
  endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// Bundle between the clock_gen/memory side (master) and the sequencer (slave).
// All signals are plain levels sampled on the rising CLK edge; there is no
// valid/ready pairing: PH1/PH2 edges act as the only "transfer" events.
interface cycle_sequencer_if #(parameter int CNT_W = 8);
  logic             ph1;
  logic             ph2;
  logic             waitN;
  logic             holdReq;
  logic [7:0]       tOneHot;
  logic [2:0]       subCyc;
  logic             sync;
  logic             fetch;
  logic             adv;
  logic             holdAck;
  logic [CNT_W-1:0] cycCnt;
  logic             phaseErr;
  logic             waitTo;
  logic [3:0]       dbgState;

  modport master (
    output ph1, ph2, waitN, holdReq,
    input  tOneHot, subCyc, sync, fetch, adv, holdAck, cycCnt, phaseErr, waitTo, dbgState
  );

  modport slave (
    input  ph1, ph2, waitN, holdReq,
    output tOneHot, subCyc, sync, fetch, adv, holdAck, cycCnt, phaseErr, waitTo, dbgState
  );
endinterface

// File: rtl/cycle_sequencer_phase_edge_det.sv
// Detects PH1/PH2 rising edges, tracks the PH1->PH2 pairing and flags
// phase-protocol faults once the first PH1 rise has been seen.
module phase_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic ph1,
  input  logic ph2,
  output logic ev,
  output logic phaseErr
);
  logic ph1Q, ph2Q, armed, locked;
  logic p1r, p2r, fault;

  assign p1r = ph1 & ~ph1Q;
  assign p2r = ph2 & ~ph2Q;
  // Coincident rises re-arm but never advance.
  assign ev    = p2r & ~p1r & armed & locked;
  assign fault = locked & ((ph1 & ph2) | (p2r & ~armed));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph1Q     <= 1'b0;
      ph2Q     <= 1'b0;
      armed    <= 1'b0;
      locked   <= 1'b0;
      phaseErr <= 1'b0;
    end else begin
      ph1Q <= ph1;
      ph2Q <= ph2;
      if (p1r) begin
        armed  <= 1'b1;
        locked <= 1'b1;
      end else if (p2r) begin
        armed <= 1'b0;
      end
      if (fault) phaseErr <= 1'b1;
    end
  end
endmodule

// File: rtl/cycle_sequencer.sv
// Eight-subcycle instruction sequencer driven by clock_gen phase edges, with
// M2 wait states, bus hold, an instruction-cycle counter and sticky faults.
module cycle_sequencer
  import cpu_timing_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  cycle_sequencer_if.slave bus
);
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t           state, nextState;
  logic             ev, phaseErrW;
  logic [7:0]       waitCnt;
  logic [CNT_W-1:0] cycCntQ;
  logic [7:0]       tOneHotQ;
  logic [2:0]       subCycQ;
  logic             syncQ, fetchQ, advQ, holdAckQ, waitToQ;
  logic             waitStay;

  phase_edge_det u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .ph1      (bus.ph1),
    .ph2      (bus.ph2),
    .ev       (ev),
    .phaseErr (phaseErrW)
  );

  assign waitStay = !bus.waitN && (waitCnt < WAIT_LIM);

  always_comb begin
    nextState = state;
    if (ev) begin
      case (state)
        ST_M2:          if (!waitStay) nextState = ST_X1;
        ST_X3, ST_HOLD: nextState = bus.holdReq ? ST_HOLD : ST_A1;
        default:        nextState = state_t'(4'(state) + 4'd1);
      endcase
    end
  end

  // Outputs are decoded from nextState so they land together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_A1;
      tOneHotQ <= OH_A1;
      subCycQ  <= SC_A1;
      syncQ    <= 1'b0;
      fetchQ   <= 1'b0;
      advQ     <= 1'b0;
      holdAckQ <= 1'b0;
      waitCnt  <= 8'd0;
      cycCntQ  <= '0;
      waitToQ  <= 1'b0;
    end else begin
      state    <= nextState;
      tOneHotQ <= oneHotOf(nextState);
      subCycQ  <= subCycOf(nextState);
      syncQ    <= (nextState == ST_X3);
      fetchQ   <= (nextState == ST_M1) || (nextState == ST_M2);
      advQ     <= (nextState != state);
      holdAckQ <= (nextState == ST_HOLD);
      if (ev && state == ST_M2) begin
        if (waitStay) begin
          waitCnt <= waitCnt + 8'd1;
        end else begin
          waitCnt <= 8'd0;
          if (!bus.waitN) waitToQ <= 1'b1;
        end
      end
      if (ev && state == ST_X3) cycCntQ <= cycCntQ + CNT_W'(1);
    end
  end

  assign bus.tOneHot  = tOneHotQ;
  assign bus.subCyc   = subCycQ;
  assign bus.sync     = syncQ;
  assign bus.fetch    = fetchQ;
  assign bus.adv      = advQ;
  assign bus.holdAck  = holdAckQ;
  assign bus.cycCnt   = cycCntQ;
  assign bus.phaseErr = phaseErrW;
  assign bus.waitTo   = waitToQ;
  assign bus.dbgState = state;
endmodule
